// File: rtl/param_rr_fifo_arbiter.sv
// N-channel round-robin arbiter over per-channel FIFOs with one registered valid/ready output.
// mode=0 rotates one channel per accept slot; mode=1 grants the first non-empty channel from ptr.

module param_rr_fifo_ch #(
   parameter int DW    = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wen,
   input  logic [DW-1:0]              din,
   input  logic                       pop,
   output logic [$clog2(DEPTH):0]     count,
   output logic [DW-1:0]              head,
   output logic                       full,
   output logic                       ovf
);
   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic          wr_acc;

   // full comes from the registered count, so a same-cycle pop never frees room for a write
   assign full   = (count_q == (AW+1)'(DEPTH));
   assign wr_acc = wen && !full;

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q | (wen & full);
      if (wr_acc) begin
         mem_d[wptr_q] = din;
         wptr_d        = wptr_q + 1'b1;
      end
      if (pop) rptr_d = rptr_q + 1'b1;
      case ({wr_acc, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // storage needs no reset: a zero count makes every entry unreachable
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign count = count_q;
   assign head  = mem_q[rptr_q];
   assign ovf   = ovf_q;
endmodule

module param_rr_fifo_arbiter #(
   parameter int N_CH  = 4,
   parameter int DW    = 8,
   parameter int DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [N_CH-1:0]           wen,
   input  logic [N_CH*DW-1:0]        din,
   input  logic                      ready,
   output logic [N_CH-1:0]           full,
   output logic [N_CH-1:0]           ovf,
   output logic [DW-1:0]             dout,
   output logic                      valid,
   output logic [$clog2(N_CH)-1:0]   src
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = $clog2(N_CH);

   logic [N_CH-1:0][AW:0]   count;
   logic [N_CH-1:0][DW-1:0] head;
   logic [N_CH-1:0]         nonempty;
   logic [N_CH-1:0]         pop;

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] src_q, src_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          valid_q, valid_d;
   logic          found;
   logic [PW-1:0] grant, idx;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      param_rr_fifo_ch #(.DW(DW), .DEPTH(DEPTH)) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .wen   (wen[g]),
         .din   (din[g*DW +: DW]),
         .pop   (pop[g]),
         .count (count[g]),
         .head  (head[g]),
         .full  (full[g]),
         .ovf   (ovf[g])
      );
      assign nonempty[g] = |count[g];
   end

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(N_CH-1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      ptr_d   = ptr_q;
      src_d   = src_q;
      dout_d  = dout_q;
      valid_d = valid_q;
      pop     = '0;
      found   = 1'b0;
      grant   = ptr_q;
      idx     = ptr_q;
      if (!valid_q || ready) begin
         if (!mode) begin
            found = nonempty[ptr_q];
            ptr_d = wrap_inc(ptr_q);
         end else begin
            for (int k = 0; k < N_CH; k++) begin
               if (!found && nonempty[idx]) begin
                  found = 1'b1;
                  grant = idx;
               end
               idx = wrap_inc(idx);
            end
            // an idle scan leaves ptr where it was
            if (found) ptr_d = wrap_inc(grant);
         end
         valid_d = found;
         if (found) begin
            pop[grant] = 1'b1;
            dout_d     = head[grant];
            src_d      = grant;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         src_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         src_q   <= src_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

   assign dout  = dout_q;
   assign valid = valid_q;
   assign src   = src_q;
endmodule

// File: tb/tb_param_rr_fifo_arbiter.sv
// Directed bench for param_rr_fifo_arbiter (4 channels, 8-bit data, 8-deep FIFOs).
module tb_param_rr_fifo_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        mode;
   logic [3:0]  wen;
   logic [31:0] din;
   logic        ready;
   logic [3:0]  full, ovf;
   logic [7:0]  dout;
   logic        valid;
   logic [1:0]  src;

   int n_pass = 0;
   int n_total = 0;

   param_rr_fifo_arbiter #(.N_CH(4), .DW(8), .DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .wen(wen), .din(din), .ready(ready),
      .full(full), .ovf(ovf), .dout(dout), .valid(valid), .src(src)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; wen = '0; din = '0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      mode = 1'b0; ready = 1'b1;
      do_reset();
      n_total++;
      if ({valid, src, dout, full, ovf} !== 19'd0)
         $display("FAIL reset_state got v=%b s=%0d d=%0d full=%b ovf=%b exp all zero", valid, src, dout, full, ovf);
      else n_pass++;
   endtask

   task automatic test_mode0_rotation();
      int exp_d[4] = '{2, 3, 4, 1};
      int exp_s[4] = '{1, 2, 3, 0};
      mode = 1'b0; ready = 1'b1;
      do_reset();
      wen = 4'b1111; din = {8'd4, 8'd3, 8'd2, 8'd1};
      tick();
      wen = '0;
      n_total++;
      if (valid !== 1'b0) $display("FAIL t1_no_bypass got v=%b exp 0", valid);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_total++;
         if ({valid, src, dout} !== {1'b1, 2'(exp_s[i]), 8'(exp_d[i])})
            $display("FAIL t1_word%0d got v=%b s=%0d d=%0d exp v=1 s=%0d d=%0d", i, valid, src, dout, exp_s[i], exp_d[i]);
         else n_pass++;
      end
      tick();
      n_total++;
      if (valid !== 1'b0) $display("FAIL t1_drain got v=%b exp 0", valid);
      else n_pass++;
   endtask

   task automatic test_mode1_skip();
      mode = 1'b1; ready = 1'b1;
      do_reset();
      wen = 4'b1000; din = {8'd85, 24'd0};
      tick();
      wen = 4'b0100; din = {8'd0, 8'd139, 16'd0};
      tick();
      wen = '0;
      n_total++;
      if ({valid, src, dout} !== {1'b1, 2'd3, 8'd85})
         $display("FAIL t2_ch3 got v=%b s=%0d d=%0d exp v=1 s=3 d=85", valid, src, dout);
      else n_pass++;
      tick();
      n_total++;
      if ({valid, src, dout} !== {1'b1, 2'd2, 8'd139})
         $display("FAIL t2_ch2 got v=%b s=%0d d=%0d exp v=1 s=2 d=139", valid, src, dout);
      else n_pass++;
      tick();
      n_total++;
      if (valid !== 1'b0) $display("FAIL t2_idle got v=%b exp 0", valid);
      else n_pass++;
   endtask

   task automatic test_overflow();
      mode = 1'b1; ready = 1'b0;
      do_reset();
      for (int w = 0; w < 10; w++) begin
         wen = 4'b0001; din = {24'd0, 8'(w)};
         tick();
         if (w == 1) begin
            n_total++;
            if ({valid, src, dout} !== {1'b1, 2'd0, 8'd0})
               $display("FAIL t3_head_held got v=%b s=%0d d=%0d exp v=1 s=0 d=0", valid, src, dout);
            else n_pass++;
         end
         if (w == 8) begin
            n_total++;
            if ({full[0], ovf[0]} !== 2'b10)
               $display("FAIL t3_full got full=%b ovf=%b exp full=1 ovf=0", full[0], ovf[0]);
            else n_pass++;
         end
      end
      wen = '0;
      n_total++;
      if ({full, ovf, valid, dout} !== {4'b0001, 4'b0001, 1'b1, 8'd0})
         $display("FAIL t3_dropped got full=%b ovf=%b v=%b d=%0d exp full=0001 ovf=0001 v=1 d=0", full, ovf, valid, dout);
      else n_pass++;
      ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         n_total++;
         if ({valid, src, dout} !== {1'b1, 2'd0, 8'(k)})
            $display("FAIL t3_drain%0d got v=%b s=%0d d=%0d exp v=1 s=0 d=%0d", k, valid, src, dout, k);
         else n_pass++;
      end
      tick();
      n_total++;
      if ({valid, full[0], ovf[0]} !== 3'b001)
         $display("FAIL t3_end got v=%b full=%b ovf=%b exp v=0 full=0 ovf=1", valid, full[0], ovf[0]);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      mode = 1'b1; ready = 1'b0;
      do_reset();
      wen = 4'b0010; din = {16'd0, 8'd10, 8'd0};
      tick();
      din = {16'd0, 8'd11, 8'd0};
      tick();
      wen = '0;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_total++;
         if ({valid, src, dout} !== {1'b1, 2'd1, 8'd10})
            $display("FAIL t4_hold%0d got v=%b s=%0d d=%0d exp v=1 s=1 d=10", c, valid, src, dout);
         else n_pass++;
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      n_total++;
      if ({valid, src, dout} !== {1'b1, 2'd1, 8'd11})
         $display("FAIL t4_step got v=%b s=%0d d=%0d exp v=1 s=1 d=11", valid, src, dout);
      else n_pass++;
      tick();
      n_total++;
      if ({valid, dout} !== {1'b1, 8'd11})
         $display("FAIL t4_rehold got v=%b d=%0d exp v=1 d=11", valid, dout);
      else n_pass++;
      ready = 1'b1;
      tick();
      n_total++;
      if (valid !== 1'b0) $display("FAIL t4_empty got v=%b exp 0", valid);
      else n_pass++;
   endtask

   task automatic test_reset_midstream();
      mode = 1'b0; ready = 1'b0;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         wen = 4'b1111; din = {8'(8'h30 + k), 8'(8'h20 + k), 8'(8'h10 + k), 8'(k)};
         tick();
      end
      for (int k = 0; k < 7; k++) begin
         wen = 4'b0100; din = {8'h00, 8'(8'hA0 + k), 16'd0};
         tick();
      end
      wen = '0;
      n_total++;
      if ({full, ovf, valid} !== {4'b0100, 4'b0100, 1'b1})
         $display("FAIL t5_loaded got full=%b ovf=%b v=%b exp full=0100 ovf=0100 v=1", full, ovf, valid);
      else n_pass++;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_total++;
      if ({valid, dout, full, ovf} !== 17'd0)
         $display("FAIL t5_cleared got v=%b d=%0d full=%b ovf=%b exp all zero", valid, dout, full, ovf);
      else n_pass++;
      mode = 1'b1; ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         n_total++;
         if (valid !== 1'b0) $display("FAIL t5_stale%0d got v=%b d=%0d exp v=0", c, valid, dout);
         else n_pass++;
      end
   endtask

   task automatic test_write_pop_same_cycle();
      mode = 1'b1; ready = 1'b1;
      do_reset();
      wen = 4'b0010; din = {16'd0, 8'd50, 8'd0};
      tick();
      n_total++;
      if (valid !== 1'b0) $display("FAIL t6_latency got v=%b exp 0", valid);
      else n_pass++;
      din = {16'd0, 8'd51, 8'd0};
      tick();
      wen = '0;
      n_total++;
      if ({valid, src, dout} !== {1'b1, 2'd1, 8'd50})
         $display("FAIL t6_old_head got v=%b s=%0d d=%0d exp v=1 s=1 d=50", valid, src, dout);
      else n_pass++;
      tick();
      n_total++;
      if ({valid, src, dout} !== {1'b1, 2'd1, 8'd51})
         $display("FAIL t6_new_word got v=%b s=%0d d=%0d exp v=1 s=1 d=51", valid, src, dout);
      else n_pass++;
      tick();
      n_total++;
      if (valid !== 1'b0) $display("FAIL t6_empty got v=%b exp 0", valid);
      else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0; mode = 1'b0; wen = '0; din = '0; ready = 1'b0;
      test_reset();
      test_mode0_rotation();
      test_mode1_skip();
      test_overflow();
      test_backpressure();
      test_reset_midstream();
      test_write_pop_same_cycle();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
